pipelined_adder: RTL and testbench

- Parametrised, pipelined add/subtract unit; successor to the combinational half adder.
- Generalises it to WIDTH-bit operands with carry-in, subtract mode, signed-overflow flag and a STAGES-deep carry-chunked pipeline.
- Uses valid/ready handshakes on input and output.
- Sits in datapaths as the standard registered arithmetic primitive.

---
 rtl/pipelined_adder_if.sv | 32 +++
 rtl/pipelined_adder.sv | 115 +++++++++++
 tb/tb_pipelined_adder.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipelined_adder_if.sv
`default_nettype none
// ============================================================================
// Module   : pipelined_adder_if
// Purpose  : Operand/result handshake bundle for pipelined_adder.
// Revision : 1.0 - initial release
// ============================================================================
interface pipelined_adder_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             CI;
  logic             SUB;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] Y;
  logic             C;
  logic             V;

  modport master (
    output in_valid, A, B, CI, SUB, out_ready,
    input  in_ready, out_valid, Y, C, V
  );

  modport slave (
    input  in_valid, A, B, CI, SUB, out_ready,
    output in_ready, out_valid, Y, C, V
  );
endinterface
`default_nettype wire

// File: rtl/pipelined_adder.sv
`default_nettype none
// ============================================================================
// Module   : pipelined_adder
// Purpose  : WIDTH-bit add/subtract with carry-in and overflow, split into
//            STAGES carry-chunked pipeline stages with valid/ready flow control.
// Revision : 1.0 - initial release
// ============================================================================
module pipelined_adder #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  pipelined_adder_if.slave bus
);

  localparam int W = WIDTH / STAGES;

  if (WIDTH < 2 || STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_param_check
    $error("pipelined_adder: illegal WIDTH/STAGES combination");
  end

  logic             advance;
  logic             out_vld_q;
  logic [WIDTH-1:0] y_q;
  logic             c_q;
  logic             v_q;

  assign advance       = bus.out_ready || !out_vld_q;
  assign bus.in_ready  = advance;
  assign bus.out_valid = out_vld_q;
  assign bus.Y         = out_vld_q ? y_q : '0;
  assign bus.C         = out_vld_q & c_q;
  assign bus.V         = out_vld_q & v_q;

  // Each stage word holds {results so far, remaining A/B chunk pairs}; the
  // low 2*W bits are always the chunk pair this stage consumes (B low, A high).
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int XW = 2 * WIDTH - k * W;

    logic [XW-1:0] x_in;
    logic          v_in;
    logic          s_in;
    logic          c_in;
    logic [W-1:0]  a_c;
    logic [W-1:0]  b_c;
    logic [W-1:0]  s;
    logic          co;

    if (k == 0) begin : g_first
      for (genvar j = 0; j < STAGES; j++) begin : g_ilv
        assign x_in[2*W*j +: W]     = bus.B[W*j +: W];
        assign x_in[2*W*j + W +: W] = bus.A[W*j +: W];
      end
      assign v_in = bus.in_valid;
      assign s_in = bus.SUB;
      assign c_in = bus.CI ^ bus.SUB;
    end else begin : g_next
      assign x_in = g_stage[k-1].g_mid.x_q;
      assign v_in = g_stage[k-1].g_mid.vld_q;
      assign s_in = g_stage[k-1].g_mid.sub_q;
      assign c_in = g_stage[k-1].g_mid.cy_q;
    end

    assign a_c       = x_in[2*W-1:W];
    assign b_c       = x_in[W-1:0] ^ {W{s_in}};
    assign {co, s}   = {1'b0, a_c} + {1'b0, b_c} + {{W{1'b0}}, c_in};

    if (k < STAGES - 1) begin : g_mid
      logic [XW-W-1:0] x_q;
      logic            vld_q;
      logic            sub_q;
      logic            cy_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          x_q   <= '0;
          vld_q <= 1'b0;
          sub_q <= 1'b0;
          cy_q  <= 1'b0;
        end else if (advance) begin
          x_q   <= {s, x_in[XW-1:2*W]};
          vld_q <= v_in;
          sub_q <= s_in;
          cy_q  <= co;
        end
      end
    end else begin : g_last
      logic [WIDTH-1:0] y_d;

      if (STAGES == 1) begin : g_one
        assign y_d = s;
      end else begin : g_many
        assign y_d = {s, x_in[XW-1:2*W]};
      end

      // Overflow: operands agree in sign but the sum's sign differs.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          out_vld_q <= 1'b0;
          y_q       <= '0;
          c_q       <= 1'b0;
          v_q       <= 1'b0;
        end else if (advance) begin
          out_vld_q <= v_in;
          y_q       <= y_d;
          c_q       <= co;
          v_q       <= (a_c[W-1] == b_c[W-1]) && (s[W-1] != a_c[W-1]);
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pipelined_adder.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipelined_adder
// Purpose  : Self-checking bench: 8-bit/2-stage directed vectors plus 4-bit
//            exhaustive streams at 1, 2 and 4 stages with random backpressure.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipelined_adder;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       ci;
    logic       sub;
    logic [7:0] y;
    logic       c;
    logic       v;
  } vec_t;

  logic clk    = 1'b0;
  logic rst_n  = 1'b1;
  logic rst4_n = 1'b1;
  int   applied     = 0;
  int   miscompares = 0;
  int   x4_finished = 0;
  int   emitted8    = 0;
  int   q8[$];

  always #5 clk = ~clk;

  pipelined_adder_if #(.WIDTH(8)) bus8 ();
  pipelined_adder #(.WIDTH(8), .STAGES(2)) u_dut8 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus8)
  );

  // Reference: unsigned result for Y/C, signed result range for V.
  function automatic int ref_calc(int w, int a, int b, int ci, int sub);
    int m, half, sa, sb, u, r, y, c, v;
    m    = 1 << w;
    half = m / 2;
    sa   = (a >= half) ? a - m : a;
    sb   = (b >= half) ? b - m : b;
    if (sub != 0) begin
      u = a - b - ci;
      c = (u >= 0) ? 1 : 0;
      r = sa - sb - ci;
    end else begin
      u = a + b + ci;
      c = (u >= m) ? 1 : 0;
      r = sa + sb + ci;
    end
    y = ((u % m) + m) % m;
    v = (r < -half || r >= half) ? 1 : 0;
    return (v << (w + 1)) | (c << w) | y;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    applied++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive8(input logic [7:0] a, input logic [7:0] b, input logic ci, input logic sub);
    bus8.A   = a;
    bus8.B   = b;
    bus8.CI  = ci;
    bus8.SUB = sub;
  endtask

  // Called at the falling edge with inputs set; scores this cycle's handshakes.
  task automatic step8(input int exp_in, output bit accepted);
    int act;
    int exp_v;
    #1;
    accepted = bus8.in_valid && bus8.in_ready;
    if (accepted) q8.push_back(exp_in);
    if (bus8.out_valid && bus8.out_ready) begin
      act = int'({bus8.V, bus8.C, bus8.Y});
      emitted8++;
      if (q8.size() == 0) begin
        chk("sb8_unexpected", act, -1);
      end else begin
        exp_v = q8.pop_front();
        chk("sb8_result", act, exp_v);
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain8();
    bit acc;
    bus8.in_valid  = 1'b0;
    bus8.out_ready = 1'b1;
    for (int t = 0; t < 10 && q8.size() > 0; t++) step8(0, acc);
    chk("drain_empty", q8.size(), 0);
  endtask

  for (genvar i = 0; i < 3; i++) begin : g_x4
    localparam int ST = (i == 0) ? 1 : ((i == 1) ? 2 : 4);

    pipelined_adder_if #(.WIDTH(4)) bus4 ();
    pipelined_adder #(.WIDTH(4), .STAGES(ST)) u_dut4 (
      .clk  (clk),
      .rst_n(rst4_n),
      .bus  (bus4)
    );

    initial begin
      int q[$];
      int idx;
      int got;
      int cyc;
      int act;
      int e;
      idx = 0;
      got = 0;
      cyc = 0;
      bus4.in_valid  = 1'b0;
      bus4.out_ready = 1'b0;
      bus4.A = '0; bus4.B = '0; bus4.CI = 1'b0; bus4.SUB = 1'b0;
      @(posedge rst4_n);
      @(negedge clk);
      while (got < 1024 && cyc < 20000) begin
        bus4.in_valid  = (idx < 1024);
        bus4.A         = 4'(idx);
        bus4.B         = 4'(idx >> 4);
        bus4.CI        = idx[8];
        bus4.SUB       = idx[9];
        bus4.out_ready = ($urandom_range(0, 3) != 0);
        #1;
        if (bus4.in_valid && bus4.in_ready) begin
          q.push_back(ref_calc(4, idx % 16, (idx / 16) % 16, (idx / 256) % 2, idx / 512));
          idx++;
        end
        if (bus4.out_valid && bus4.out_ready) begin
          act = int'({bus4.V, bus4.C, bus4.Y});
          e   = (q.size() > 0) ? q.pop_front() : -1;
          chk($sformatf("x4_st%0d_beat%0d", ST, got), act, e);
          got++;
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
      end
      chk($sformatf("x4_st%0d_count", ST), got, 1024);
      x4_finished++;
    end
  end

  initial begin
    vec_t tbl[10];
    bit   acc;
    int   i;
    int   cyc;
    int   held_val;
    bit   held;

    tbl[0] = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
    tbl[1] = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1};
    tbl[2] = '{8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0};
    tbl[3] = '{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1};
    tbl[4] = '{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1};
    tbl[5] = '{8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0};
    tbl[6] = '{8'h00, 8'h00, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0};
    tbl[7] = '{8'h7F, 8'hFF, 1'b0, 1'b1, 8'h80, 1'b0, 1'b1};
    tbl[8] = '{8'h0F, 8'hF1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
    tbl[9] = '{8'h10, 8'h01, 1'b0, 1'b1, 8'h0F, 1'b1, 1'b0};

    // Reset asserted with a live input beat present.
    drive8(8'hFF, 8'hFF, 1'b0, 1'b0);
    bus8.in_valid  = 1'b1;
    bus8.out_ready = 1'b1;
    #1;
    rst_n  = 1'b0;
    rst4_n = 1'b0;
    #1;
    for (int c = 0; c < 3; c++) begin
      chk("rst_out_valid", bus8.out_valid, 0);
      chk("rst_vcy", int'({bus8.V, bus8.C, bus8.Y}), 0);
      chk("rst_in_ready", bus8.in_ready, 1);
      @(posedge clk);
      #1;
    end

    // Latency: accept on the first edge after release, result STAGES-1 edges later.
    @(negedge clk);
    rst_n  = 1'b1;
    rst4_n = 1'b1;
    drive8(8'h01, 8'h02, 1'b0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    bus8.in_valid = 1'b0;
    #1;
    chk("lat_early_valid", bus8.out_valid, 0);
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("lat_valid", bus8.out_valid, 1);
    chk("lat_result", int'({bus8.V, bus8.C, bus8.Y}), 3);
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("lat_drained", bus8.out_valid, 0);
    @(negedge clk);

    // Directed vectors, back to back.
    bus8.out_ready = 1'b1;
    foreach (tbl[n]) begin
      drive8(tbl[n].a, tbl[n].b, tbl[n].ci, tbl[n].sub);
      bus8.in_valid = 1'b1;
      step8(int'({tbl[n].v, tbl[n].c, tbl[n].y}), acc);
      chk("tbl_accept", int'(acc), 1);
    end
    drain8();

    // Backpressure: six beats, out_ready low for three cycles mid-stream.
    i        = 1;
    cyc      = 0;
    held     = 1'b0;
    held_val = 0;
    emitted8 = 0;
    while ((i <= 6 || q8.size() > 0) && cyc < 40) begin
      bus8.in_valid  = (i <= 6);
      drive8(8'(i), 8'(i), 1'b0, 1'b0);
      bus8.out_ready = !(cyc >= 3 && cyc < 6);
      #1;
      if (!bus8.out_ready) begin
        chk("bp_in_ready", bus8.in_ready, 0);
        if (held) chk("bp_hold", int'({bus8.V, bus8.C, bus8.Y}), held_val);
        held_val = int'({bus8.V, bus8.C, bus8.Y});
        held     = 1'b1;
      end
      step8(ref_calc(8, i, i, 0, 0), acc);
      if (acc) i++;
      cyc++;
    end
    chk("bp_count", emitted8, 6);

    // Async reset with the pipeline full and stalled.
    bus8.out_ready = 1'b0;
    for (int n = 0; n < 2; n++) begin
      drive8(8'(8'h10 + n), 8'h20, 1'b0, 1'b0);
      bus8.in_valid = 1'b1;
      step8(ref_calc(8, 16 + n, 32, 0, 0), acc);
    end
    bus8.in_valid = 1'b0;
    #1;
    chk("pre_rst_valid", bus8.out_valid, 1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", bus8.out_valid, 0);
    chk("async_rst_vcy", int'({bus8.V, bus8.C, bus8.Y}), 0);
    chk("async_rst_in_ready", bus8.in_ready, 1);
    q8.delete();
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    bus8.out_ready = 1'b1;
    for (int n = 0; n < 4; n++) begin
      chk("post_rst_valid", bus8.out_valid, 0);
      step8(0, acc);
    end

    for (int t = 0; t < 30000 && x4_finished < 3; t++) @(posedge clk);
    chk("x4_done", x4_finished, 3);

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
